mem_responder: RTL and testbench
================================

# mem_responder

Clocked memory responder that answers the datapath's MFA/MFC memory handshake. The datapath's MAR/MDR/MOP path acts as the initiator. The block holds a 256-byte big-endian byte array and decodes the 6-bit SPARC op3 memory opcode into byte, halfword and word loads and stores. It inserts a programmable wait latency, detects misaligned accesses, and holds the result until the initiator releases MFA.

## Interface
- WAIT_CYCLES, default 2: wait states between request capture and access commit (0..15).
- Clk  in  1  system clock; all state changes on its rising edge.
- Clr  in  1  reset, asynchronous, active-high.
- MFA  in  1  memory function active; request valid, held by initiator until MFC seen.
- opcode  in  6  op3 memory opcode, sampled with the request.
- address  in  8  byte address, sampled with the request.
- DataIn  in  32  store data, sampled with the request (byte/half taken from low bits).
- MFC  out  1  memory function complete.
- DataOut  out  32  load result; valid while MFC=1.
- MAE  out  1  memory address exception (misaligned); valid while MFC=1.

## Operation
- Opcodes:
  - 0x00, 0x08 LD word.
  - 0x01 LDUB, zero-extended.
  - 0x02 LDUH, zero-extended.
  - 0x09 LDSB, sign-extended.
  - 0x0A LDSH, sign-extended.
  - 0x04 ST word.
  - 0x05 STB, DataIn[7:0].
  - 0x06 STH, DataIn[15:0].
  - Any other opcode completes normally with no write, DataOut=0 and MAE=0.
- Byte ordering is big-endian: byte at address is the MSB. Word = {m[a], m[a+1], m[a+2], m[a+3]}.
- Alignment: a halfword needs address[0]=0; a word needs address[1:0]=0. Aligned accesses never wrap past 255.
- On a misaligned access:
  - no write;
  - DataOut keeps its previous value;
  - MAE=1 with MFC.
- States:
  - IDLE: MFC=0. If MFA=1, capture opcode, address and DataIn into internal registers, load the counter with WAIT_CYCLES, and go to WAIT.
  - WAIT: if MFA=0, abort to IDLE (no write, MFC never rises). Otherwise, if counter=0, commit the access and go to DONE. Else decrement the counter.
  - DONE: MFC=1; DataOut and MAE are held. If MFA=0, go to IDLE (MFC falls). A new request needs MFA low for at least one sampled edge.
- Commit on the WAIT→DONE edge:
  - a store updates the array;
  - a load registers DataOut from the array contents at that edge;
  - MAE is set or cleared at that edge.
- Captured inputs are used throughout. Changes to opcode, address or DataIn after capture have no effect.
- Reset forces IDLE, with MFC=0, DataOut=0, MAE=0 and counter=0. Array contents are not cleared.
- Reset arriving in WAIT discards the request with no write. A store already committed remains.

## Timing
- Capture edge n is the first rising edge with MFA=1 in IDLE.
- Commit and MFC rising occur at edge n+WAIT_CYCLES+1. With WAIT_CYCLES=0 this is edge n+1.
- MFC falls at the first edge in DONE that samples MFA=0. The earliest next capture is the following edge.
- All outputs are registered; there is no combinational path from the inputs to MFC, DataOut or MAE.
- The array is read and written synchronously at commit only. A load following a store to the same address in the next transaction returns the new data.
- Back-to-back throughput is WAIT_CYCLES+3 cycles per transaction: capture, waits plus commit, then one MFA-low cycle.

## Test plan
- Word store/load, WAIT_CYCLES=2:
  - ST 0x04 of A2044012 to addr 0x10, then LD 0x08 from addr 0x10 → DataOut=A2044012 with MAE=0.
  - MFC rises exactly 3 edges after each capture edge.
  - m[0x10]=A2 and m[0x13]=12.
- Sub-word loads after word A2044012 at 0x10:
  - LDUB @0x10 → 000000A2.
  - LDSB @0x10 → FFFFFFA2.
  - LDUH @0x12 → 00004012.
  - LDSH @0x10 → FFFFA204.
  - STB 0x7F @0x11, then LD @0x10 → A27F4012.
- Misalignment:
  - LD @0x11 → MFC=1, MAE=1, DataOut unchanged.
  - STH @0x13 → MAE=1 and memory unchanged.
  - A following aligned LD clears MAE.
- Handshake:
  - Hold MFA high 5 cycles past MFC → MFC stays high and DataOut stable.
  - Drop MFA → MFC low next edge; re-raise MFA → new capture.
  - MFA dropped during WAIT → no MFC, and a store is not written.
- Reset:
  - Assert Clr mid-WAIT on ST 0xDEADBEEF @0x20 → outputs 0 immediately (asynchronous).
  - Subsequent LD @0x20 returns the prior contents.
  - Assert Clr in DONE → MFC drops without waiting for a clock.
- Latency sweep: with WAIT_CYCLES=0 and WAIT_CYCLES=15, MFC rises at edges n+1 and n+16; invalid opcode 0x3F → MFC with DataOut=0, MAE=0.

Source files
------------

// File: rtl/mem_responder.sv
// Memory responder for the MFA/MFC handshake: 256-byte big-endian array,
// SPARC op3 load/store decode, programmable wait latency, misalignment flag.
module mem_responder #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        MFA,
  input  logic [5:0]  opcode,
  input  logic [7:0]  address,
  input  logic [31:0] DataIn,
  output logic        MFC,
  output logic [31:0] DataOut,
  output logic        MAE
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [7:0]  addr;
    logic [31:0] data;
  } req_t;

  state_t      state, state_nxt;
  req_t        req;
  logic [3:0]  cnt;
  logic [7:0]  mem [256];

  logic        is_ld, is_st, sext, misalign, commit;
  size_t       size;
  logic [7:0]  a1, a2, a3, b0, b1, b2, b3;
  logic [31:0] ld_data;

  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    sext  = 1'b0;
    size  = SZ_W;
    case (req.op)
      6'h00, 6'h08: is_ld = 1'b1;
      6'h01: begin is_ld = 1'b1; size = SZ_B; end
      6'h02: begin is_ld = 1'b1; size = SZ_H; end
      6'h09: begin is_ld = 1'b1; size = SZ_B; sext = 1'b1; end
      6'h0A: begin is_ld = 1'b1; size = SZ_H; sext = 1'b1; end
      6'h04: is_st = 1'b1;
      6'h05: begin is_st = 1'b1; size = SZ_B; end
      6'h06: begin is_st = 1'b1; size = SZ_H; end
      default: ;
    endcase
  end

  // Invalid opcodes are never flagged, whatever their address.
  assign misalign = (is_ld || is_st) &&
                    ((size == SZ_H && req.addr[0]) ||
                     (size == SZ_W && req.addr[1:0] != 2'b00));

  // Aligned accesses only ever touch bytes within their own word.
  assign a1 = {req.addr[7:1], 1'b1};
  assign a2 = {req.addr[7:2], 2'b10};
  assign a3 = {req.addr[7:2], 2'b11};
  assign b0 = mem[req.addr];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  always_comb begin
    ld_data = {b0, b1, b2, b3};
    case (size)
      SZ_B:    ld_data = {{24{sext & b0[7]}}, b0};
      SZ_H:    ld_data = {{16{sext & b0[7]}}, b0, b1};
      default: ;
    endcase
  end

  assign commit = (state == WAIT) && MFA && (cnt == 4'd0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (MFA) state_nxt = WAIT;
      WAIT:    if (!MFA) state_nxt = IDLE;
               else if (cnt == 4'd0) state_nxt = DONE;
      DONE:    if (!MFA) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state   <= IDLE;
      req     <= '0;
      cnt     <= '0;
      MFC     <= 1'b0;
      DataOut <= '0;
      MAE     <= 1'b0;
    end else begin
      state <= state_nxt;
      MFC   <= (state_nxt == DONE);
      if (state == IDLE && MFA) begin
        req <= '{op: opcode, addr: address, data: DataIn};
        cnt <= 4'(WAIT_CYCLES);
      end else if (state == WAIT && MFA && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        MAE <= misalign;
        if (!misalign) begin
          if (is_ld)       DataOut <= ld_data;
          else if (!is_st) DataOut <= '0;
        end
      end
    end
  end

  // Array is not reset; a reset during WAIT drops state first, so no write.
  always_ff @(posedge Clk) begin
    if (commit && is_st && !misalign) begin
      case (size)
        SZ_B: mem[req.addr] <= req.data[7:0];
        SZ_H: begin
          mem[req.addr] <= req.data[15:8];
          mem[a1]       <= req.data[7:0];
        end
        default: begin
          mem[req.addr] <= req.data[31:24];
          mem[a1]       <= req.data[23:16];
          mem[a2]       <= req.data[15:8];
          mem[a3]       <= req.data[7:0];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances (WAIT_CYCLES 2, 0, 15)
// sharing clock and reset, each with its own handshake signals.
module tb_mem_responder;

  logic              Clk = 1'b0;
  logic              Clr = 1'b0;
  logic [2:0]        mfa = '0;
  logic [2:0][5:0]   op  = '0;
  logic [2:0][7:0]   adr = '0;
  logic [2:0][31:0]  din = '0;
  logic [2:0]        mfc;
  logic [2:0][31:0]  dout;
  logic [2:0]        mae;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  mem_responder #(.WAIT_CYCLES(2)) u_w2 (
    .Clk(Clk), .Clr(Clr), .MFA(mfa[0]), .opcode(op[0]), .address(adr[0]),
    .DataIn(din[0]), .MFC(mfc[0]), .DataOut(dout[0]), .MAE(mae[0]));
  mem_responder #(.WAIT_CYCLES(0)) u_w0 (
    .Clk(Clk), .Clr(Clr), .MFA(mfa[1]), .opcode(op[1]), .address(adr[1]),
    .DataIn(din[1]), .MFC(mfc[1]), .DataOut(dout[1]), .MAE(mae[1]));
  mem_responder #(.WAIT_CYCLES(15)) u_w15 (
    .Clk(Clk), .Clr(Clr), .MFA(mfa[2]), .opcode(op[2]), .address(adr[2]),
    .DataIn(din[2]), .MFC(mfc[2]), .DataOut(dout[2]), .MAE(mae[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Raise MFA with a request, then scramble the inputs after the capture edge
  // and count edges until MFC rises (bounded at 40).
  task automatic req(input int d, input logic [5:0] o, input logic [7:0] a,
                     input logic [31:0] w, input int exp_lat, input string tag);
    int lat;
    @(negedge Clk);
    mfa[d] = 1'b1; op[d] = o; adr[d] = a; din[d] = w;
    @(posedge Clk);
    #1;
    op[d] = 6'h04; adr[d] = 8'hFC; din[d] = 32'h0BAD0BAD;
    lat = 0;
    while (lat < 40) begin
      @(posedge Clk);
      lat++;
      #1;
      if (mfc[d]) break;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic rel(input int d, input string tag);
    @(negedge Clk);
    mfa[d] = 1'b0;
    @(posedge Clk);
    #1;
    chk({tag, "_mfc_fall"}, 32'(mfc[d]), 32'd0);
  endtask

  task automatic ld(input int d, input logic [5:0] o, input logic [7:0] a, input int lat,
                    input logic [31:0] exp_d, input logic exp_mae, input string tag);
    req(d, o, a, 32'h0, lat, tag);
    chk({tag, "_data"}, dout[d], exp_d);
    chk({tag, "_mae"}, 32'(mae[d]), 32'(exp_mae));
    rel(d, tag);
  endtask

  task automatic st(input int d, input logic [5:0] o, input logic [7:0] a,
                    input logic [31:0] w, input int lat, input logic exp_mae, input string tag);
    req(d, o, a, w, lat, tag);
    chk({tag, "_mae"}, 32'(mae[d]), 32'(exp_mae));
    rel(d, tag);
  endtask

  initial begin
    Clr = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_mfc",  32'(mfc[0]), 32'd0);
    chk("rst_dout", dout[0], 32'd0);
    chk("rst_mae",  32'(mae[0]), 32'd0);
    @(negedge Clk);
    Clr = 1'b0;

    // word store/load and sub-word loads
    st(0, 6'h04, 8'h10, 32'hA2044012, 3, 1'b0, "st_w");
    ld(0, 6'h08, 8'h10, 3, 32'hA2044012, 1'b0, "ld_w");
    ld(0, 6'h01, 8'h10, 3, 32'h000000A2, 1'b0, "ldub");
    ld(0, 6'h09, 8'h10, 3, 32'hFFFFFFA2, 1'b0, "ldsb");
    ld(0, 6'h02, 8'h12, 3, 32'h00004012, 1'b0, "lduh");
    ld(0, 6'h0A, 8'h10, 3, 32'hFFFFA204, 1'b0, "ldsh");
    ld(0, 6'h01, 8'h13, 3, 32'h00000012, 1'b0, "ldub13");
    st(0, 6'h05, 8'h11, 32'hFFFFFF7F, 3, 1'b0, "stb");
    ld(0, 6'h00, 8'h10, 3, 32'hA27F4012, 1'b0, "ld_after_stb");

    // misalignment
    ld(0, 6'h00, 8'h11, 3, 32'hA27F4012, 1'b1, "ld_mis");
    st(0, 6'h06, 8'h13, 32'h0000BEEF, 3, 1'b1, "sth_mis");
    ld(0, 6'h00, 8'h10, 3, 32'hA27F4012, 1'b0, "ld_clear");

    // MFA held past MFC
    req(0, 6'h02, 8'h10, 32'h0, 3, "hold");
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk);
      #1;
      chk("hold_mfc", 32'(mfc[0]), 32'd1);
      chk("hold_data", dout[0], 32'h0000A27F);
    end
    rel(0, "hold");
    ld(0, 6'h00, 8'h10, 3, 32'hA27F4012, 1'b0, "recapture");

    // abort during WAIT
    st(0, 6'h04, 8'h30, 32'h55667788, 3, 1'b0, "st30");
    @(negedge Clk);
    mfa[0] = 1'b1; op[0] = 6'h04; adr[0] = 8'h30; din[0] = 32'h11111111;
    @(negedge Clk);
    mfa[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk);
      #1;
      chk("abort_mfc", 32'(mfc[0]), 32'd0);
    end
    ld(0, 6'h00, 8'h30, 3, 32'h55667788, 1'b0, "ld_after_abort");

    // reset mid-WAIT discards a store
    st(0, 6'h04, 8'h20, 32'h01020304, 3, 1'b0, "st20");
    ld(0, 6'h00, 8'h30, 3, 32'h55667788, 1'b0, "ld30_again");
    @(negedge Clk);
    mfa[0] = 1'b1; op[0] = 6'h04; adr[0] = 8'h20; din[0] = 32'hDEADBEEF;
    @(posedge Clk);
    @(posedge Clk);
    #2;
    Clr = 1'b1;
    #1;
    chk("rstw_mfc",  32'(mfc[0]), 32'd0);
    chk("rstw_dout", dout[0], 32'd0);
    chk("rstw_mae",  32'(mae[0]), 32'd0);
    @(negedge Clk);
    Clr = 1'b0; mfa[0] = 1'b0;
    ld(0, 6'h00, 8'h20, 3, 32'h01020304, 1'b0, "ld_after_rst");

    // reset while in DONE
    req(0, 6'h00, 8'h20, 32'h0, 3, "rstd");
    #2;
    Clr = 1'b1;
    #1;
    chk("rstd_mfc",  32'(mfc[0]), 32'd0);
    chk("rstd_dout", dout[0], 32'd0);
    @(negedge Clk);
    Clr = 1'b0; mfa[0] = 1'b0;

    // latency sweep and invalid opcode
    st(1, 6'h04, 8'h40, 32'hCAFEF00D, 1, 1'b0, "w0_st");
    ld(1, 6'h08, 8'h40, 1, 32'hCAFEF00D, 1'b0, "w0_ld");
    st(2, 6'h04, 8'h40, 32'h89ABCDEF, 16, 1'b0, "w15_st");
    ld(2, 6'h00, 8'h40, 16, 32'h89ABCDEF, 1'b0, "w15_ld");
    ld(2, 6'h3F, 8'h41, 16, 32'h00000000, 1'b0, "w15_inv");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
